// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory request arbiter.
//   - default parameter values (data width, CPU address width, clear depth, latency)
//   - controller read/write encoding, FSM states, requester port ids
//   - alignment helper used when a request is granted
package mem_arbiter_pkg;

  localparam int DWIDTH_DEF    = 32;
  localparam int CPUAWIDTH_DEF = 16;
  localparam int MEMDEPTH_DEF  = 16;
  localparam int MEM_LAT_DEF   = 4;

  // Controller encoding of mem_rw.
  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_t;

  // Word accesses only: any nonzero byte offset is rejected.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin picker.
//   clk, reset : clock / asynchronous active-high reset
//   req_if     : fetch port pending
//   req_dm     : data port pending
//   take       : the current winner is being granted this cycle
//   any        : at least one port pending
//   winner     : port that wins now (only meaningful with any)
// last_grant remembers the port served most recently; on a tie the other
// port wins. It resets to PORT_IF so the data port wins the first tie.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  req_if,
  input  logic  req_dm,
  input  logic  take,
  output logic  any,
  output port_t winner
);

  port_t last_grant_reg;

  assign any = req_if | req_dm;

  always_comb begin
    winner = PORT_IF;
    if (req_if && req_dm)
      winner = (last_grant_reg == PORT_IF) ? PORT_DM : PORT_IF;
    else if (req_dm)
      winner = PORT_DM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant_reg <= PORT_IF;
    else if (take && any)
      last_grant_reg <= winner;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data requests onto a single
// memory-controller bus, one access at a time.
//   clk, reset                      : clock / asynchronous active-high reset
//   if_req, if_addr                 : fetch request (level, held until if_ack)
//   if_rdata, if_ack, if_err        : fetch response, valid with the 1-cycle ack
//   dm_req, dm_we, dm_addr, dm_wdata: data load/store request
//   dm_rdata, dm_ack, dm_err        : data response, valid with the 1-cycle ack
//   mem_valid, mem_rw, mem_addr     : controller strobe, held for MEM_LAT cycles
//   mem_data                        : shared bus, driven only during a write window
//   init_busy                       : high while the controller clears memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int CPUAWIDTH = CPUAWIDTH_DEF,
  parameter int MEMDEPTH  = MEMDEPTH_DEF,
  parameter int MEM_LAT   = MEM_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [CPUAWIDTH-1:0] if_addr,
  output logic [DWIDTH-1:0]    if_rdata,
  output logic                 if_ack,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [CPUAWIDTH-1:0] dm_addr,
  input  logic [DWIDTH-1:0]    dm_wdata,
  output logic [DWIDTH-1:0]    dm_rdata,
  output logic                 dm_ack,
  output logic                 dm_err,
  output logic                 if_err,
  output logic                 mem_valid,
  output logic                 mem_rw,
  output logic [CPUAWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0]    mem_data,
  output logic                 init_busy
);

  localparam int LAT_W  = $clog2(MEM_LAT + 1);
  localparam int INIT_W = $clog2(MEMDEPTH + 3);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LAT);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(MEMDEPTH + 1);

  state_t               state_reg;
  logic [LAT_W-1:0]     lat_cnt_reg;
  logic [INIT_W-1:0]    init_cnt_reg;
  port_t                grant_port_reg;
  logic [DWIDTH-1:0]    wdata_reg;

  logic                 arb_any;
  port_t                arb_winner;
  logic                 sel_dm;
  logic [CPUAWIDTH-1:0] req_addr;
  logic                 req_we;
  logic [DWIDTH-1:0]    rd_value;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req_if (if_req),
    .req_dm (dm_req),
    .take   (state_reg == ST_IDLE),
    .any    (arb_any),
    .winner (arb_winner)
  );

  // Fields of whichever port wins this cycle; fetches are always reads.
  assign sel_dm   = (arb_winner == PORT_DM);
  assign req_addr = sel_dm ? dm_addr : if_addr;
  assign req_we   = sel_dm & dm_we;

  // Stores return zero data; reads take the bus value on the last window cycle.
  assign rd_value = (mem_rw == MEM_RD) ? mem_data : '0;

  // The enable comes straight from registers, so an asynchronous reset
  // releases the bus in the same cycle it is asserted.
  assign mem_data = (mem_valid && mem_rw == MEM_WR) ? wdata_reg : 'z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_INIT;
      lat_cnt_reg    <= '0;
      init_cnt_reg   <= '0;
      grant_port_reg <= PORT_IF;
      wdata_reg      <= '0;
      init_busy      <= 1'b1;
      mem_valid      <= 1'b0;
      mem_rw         <= 1'b0;
      mem_addr       <= '0;
      if_ack         <= 1'b0;
      dm_ack         <= 1'b0;
      if_err         <= 1'b0;
      dm_err         <= 1'b0;
      if_rdata       <= '0;
      dm_rdata       <= '0;
    end else begin
      // Responses are single-cycle; they default back to zero.
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_err   <= 1'b0;
      dm_err   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;

      unique case (state_reg)
        ST_INIT: begin
          // Counter stops at its last value rather than wrapping.
          if (init_cnt_reg == INIT_LAST) begin
            state_reg <= ST_IDLE;
            init_busy <= 1'b0;
          end else begin
            init_cnt_reg <= init_cnt_reg + INIT_W'(1);
          end
        end

        ST_IDLE: begin
          if (arb_any) begin
            grant_port_reg <= arb_winner;
            if (misaligned(req_addr[1:0])) begin
              // Rejected without touching the controller.
              state_reg <= ST_ACK;
              if (sel_dm) begin
                dm_ack <= 1'b1;
                dm_err <= 1'b1;
              end else begin
                if_ack <= 1'b1;
                if_err <= 1'b1;
              end
            end else begin
              state_reg   <= ST_ACCESS;
              mem_valid   <= 1'b1;
              mem_addr    <= req_addr;
              mem_rw      <= req_we ? MEM_WR : MEM_RD;
              wdata_reg   <= dm_wdata;
              lat_cnt_reg <= LAT_W'(1);
            end
          end
        end

        ST_ACCESS: begin
          if (lat_cnt_reg == LAT_LAST) begin
            state_reg <= ST_ACK;
            mem_valid <= 1'b0;
            if (grant_port_reg == PORT_DM) begin
              dm_ack   <= 1'b1;
              dm_rdata <= rd_value;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= rd_value;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
          end
        end

        ST_ACK: begin
          // Guarantees a strobe-low cycle before the next grant.
          state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 16;
  localparam int LAT   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          if_ack, dm_ack, if_err, dm_err;
  logic          mem_valid, mem_rw, init_busy;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DWIDTH(DW), .CPUAWIDTH(AW), .MEMDEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err), .if_err(if_err),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_data(mem_data), .init_busy(init_busy)
  );

  // ---------------- memory controller model ----------------
  function automatic logic [DW-1:0] power_on_word(input int w);
    return (w == 16) ? 32'hDEADBEEF : (32'hC0DE_0000 | DW'(w));
  endfunction

  logic [DW-1:0] ctrl_mem [0:255];
  logic          ctrl_written [0:255];
  logic          ctrl_clear;
  logic          probe_en;
  logic [DW-1:0] ctrl_rd;

  always_comb begin
    ctrl_rd = ctrl_written[mem_addr[9:2]] ? ctrl_mem[mem_addr[9:2]]
                                          : power_on_word(int'(mem_addr[9:2]));
  end

  assign mem_data = (mem_valid && mem_rw == 1'b1) ? ctrl_rd : 'z;
  // Probe pulls the bus to zero so a released bus reads back as 0.
  assign mem_data = probe_en ? '0 : 'z;

  always @(posedge clk) begin
    if (ctrl_clear) begin
      for (int i = 0; i < 256; i++) ctrl_written[i] <= 1'b0;
    end else if (mem_valid && mem_rw == 1'b0) begin
      ctrl_mem[mem_addr[9:2]]     <= mem_data;
      ctrl_written[mem_addr[9:2]] <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] ref_read(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : power_on_word(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one request from a posedge+1 point in an IDLE cycle, follows it
  // to its ack and returns positioned just after the edge ending the ack cycle.
  task automatic do_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input logic exp_err, input int idx);
    int valid_cycles = 0, rw_bad = 0, addr_bad = 0, data_bad = 0, ack_at = 0;
    int ack_port = 0;
    logic [DW-1:0] got_rdata = '0;
    logic got_err = 1'b0;
    bit got = 0;
    logic exp_rw = (port == 1'b1 && we) ? 1'b0 : 1'b1;
    if (port == 1'b0) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end
    @(posedge clk);
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      if (mem_valid) begin
        valid_cycles++;
        if (mem_rw !== exp_rw) rw_bad++;
        if (mem_addr !== addr) addr_bad++;
        if (exp_rw == 1'b0 && mem_data !== wdata) data_bad++;
      end
      if (if_ack || dm_ack) begin
        got = 1;
        ack_at = k;
        ack_port = (if_ack && dm_ack) ? 2 : (dm_ack ? 1 : 0);
        got_rdata = dm_ack ? dm_rdata : if_rdata;
        got_err = dm_ack ? dm_err : if_err;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
    end else begin
      check("ack_latency", ack_at, exp_err ? 1 : LAT + 1);
      check("valid_cycles", valid_cycles, exp_err ? 0 : LAT);
      check("rw_stable", rw_bad, 0);
      check("addr_stable", addr_bad, 0);
      check("wdata_on_bus", data_bad, 0);
      check("ack_port", ack_port, int'(port));
      check("rdata", got_rdata, exp_rdata);
      check("err", 32'(got_err), 32'(exp_err));
    end
    $display("txn %0d port=%s we=%0d addr=%h wdata=%h rdata=%h err=%0d ack_at=%0d",
             idx, port ? "DM" : "IF", we, addr, wdata, got_rdata, got_err, ack_at);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    int c = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    while (init_busy && c < 100) begin @(posedge clk); c++; end
    #1;
    if (init_busy) check("reset_init_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    int busy_cnt, cyc, ack_cnt, rises, seq_n;
    int ack_cyc[4];
    int ack_prt[4];
    logic prev_valid;

    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; probe_en = 1'b1; ctrl_clear = 1'b1;
    @(posedge clk); #1 ctrl_clear = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_if_ack", 32'(if_ack), 0);
    check("rst_dm_ack", 32'(dm_ack), 0);
    check("rst_errs", {30'd0, if_err, dm_err}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_mem_rw", 32'(mem_rw), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_data_released", mem_data, 0);
    check("rst_init_busy", 32'(init_busy), 1);
    probe_en = 1'b0;

    // Init hold-off: fetch requested while still in reset.
    if_req = 1'b1; if_addr = 16'h0040;
    @(posedge clk); #1 reset = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (init_busy) busy_cnt++; else break;
    end
    check("init_busy_len", busy_cnt, DEPTH + 2);
    check("init_no_early_valid", 32'(mem_valid), 0);
    // First non-busy cycle is IDLE; the grant edge ends it.
    cyc = 0;
    while (!mem_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check("init_first_valid_delay", cyc, 1);
    cyc = 0;
    while (!if_ack && cyc < 20) begin @(negedge clk); cyc++; end
    check("init_ack_after_valid", cyc, LAT);
    check("init_if_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    @(posedge clk); #1;

    // Directed table
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0080, 32'h12345678, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0080, 32'h0,        32'h12345678, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h0080, 32'h0,        32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0042, 32'h0,        32'h0,        1'b1};
    vecs[5] = '{1'b0, 1'b0, 16'h0043, 32'h0,        32'h0,        1'b1};
    vecs[6] = '{1'b1, 1'b1, 16'h0081, 32'hCAFEF00D, 32'h0,        1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h0080, 32'h0,        32'h12345678, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 16'h03FC, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[9] = '{1'b0, 1'b0, 16'h03FC, 32'h0,        32'hFFFFFFFF, 1'b0};
    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, i);
      if (vecs[i].port && vecs[i].we && vecs[i].addr[1:0] == 2'b00)
        ref_mem[int'(vecs[i].addr[9:2])] = vecs[i].wdata;
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      logic          p, w, e;
      logic [AW-1:0] a;
      logic [DW-1:0] d, r;
      int            wi;
      p  = 1'($urandom_range(0, 1));
      w  = p ? 1'($urandom_range(0, 1)) : 1'b0;
      wi = int'($urandom_range(0, 255));
      a  = AW'(wi * 4);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d  = $urandom;
      e  = (a[1:0] != 2'b00);
      if (e) r = '0;
      else if (w) begin ref_mem[wi] = d; r = '0; end
      else r = ref_read(wi);
      do_txn(p, w, a, d, r, e, 100 + i);
    end

    // Contention from a fresh reset: data wins first, then strict alternation.
    do_reset();
    if_addr = 16'h0080; dm_addr = 16'h0040; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    ack_cnt = 0; rises = 0; prev_valid = 1'b0;
    for (int c = 1; c <= 100 && ack_cnt < 4; c++) begin
      @(negedge clk);
      if (mem_valid && !prev_valid) rises++;
      prev_valid = mem_valid;
      if (if_ack || dm_ack) begin
        ack_cyc[ack_cnt] = c;
        ack_prt[ack_cnt] = dm_ack ? 1 : 0;
        check("cont_rdata", dm_ack ? dm_rdata : if_rdata,
              dm_ack ? ref_read(16) : ref_read(32));
        $display("contention ack %0d port=%s cycle=%0d", ack_cnt, dm_ack ? "DM" : "IF", c);
        ack_cnt++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("cont_ack_count", ack_cnt, 4);
    check("cont_strobe_rises", rises, 4);
    for (int i = 0; i < 4 && i < ack_cnt; i++) begin
      check("cont_order", ack_prt[i], (i % 2 == 0) ? 1 : 0);
      if (i > 0) check("cont_spacing", ack_cyc[i] - ack_cyc[i-1], LAT + 2);
    end
    @(posedge clk); #1;

    // Reset on the second cycle of a store window.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0100; dm_wdata = 32'h5A5AA5A5;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("midrst_pre_valid", 32'(mem_valid), 1);
    check("midrst_pre_bus", mem_data, 32'h5A5AA5A5);
    reset = 1'b1; dm_req = 1'b0; probe_en = 1'b1;
    #1;
    check("midrst_valid_drop", 32'(mem_valid), 0);
    check("midrst_bus_released", mem_data, 0);
    check("midrst_init_busy", 32'(init_busy), 1);
    probe_en = 1'b0;
    seq_n = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if_ack || dm_ack || mem_valid) seq_n++;
    end
    check("midrst_no_ack_or_access", seq_n, 0);
    $display("reset mid-access done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-port memory request arbiter between the CPU core and the memory controller.
- Accepts instruction-fetch reads and data load/store requests, grants one at a time, and drives the controller's `valid`/`rw`/`addr`/`data` bus for a fixed latency window.
- Returns read data with a one-cycle acknowledge.
- Holds off all traffic while the controller runs its post-reset memory-clear sweep.

## Interface
- `DWIDTH`, default from params.svh: data word width.
- `CPUAWIDTH`, default from params.svh: CPU byte-address width.
- `MEMDEPTH`, default from params.svh: words cleared by the controller after reset; sets the init hold-off length.
- `MEM_LAT`, default 4: cycles `mem_valid` is held per access (≥2).
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `if_req`, in, 1: fetch request, level, held until `if_ack`.
- `if_addr`, in, CPUAWIDTH: fetch byte address.
- `if_rdata`, out, DWIDTH: fetch data, valid with `if_ack`.
- `if_ack`, out, 1: one-cycle completion pulse.
- `dm_req`, in, 1: data request, level, held until `dm_ack`.
- `dm_we`, in, 1: 1 = store, 0 = load.
- `dm_addr`, in, CPUAWIDTH: data byte address.
- `dm_wdata`, in, DWIDTH: store data.
- `dm_rdata`, out, DWIDTH: load data, valid with `dm_ack`.
- `dm_ack`, out, 1: one-cycle completion pulse.
- `dm_err`, out, 1: misaligned-address flag, valid with `dm_ack`.
- `if_err`, out, 1: misaligned-address flag, valid with `if_ack`.
- `mem_valid`, out, 1: access strobe to the controller.
- `mem_rw`, out, 1: 1 = read, 0 = write (controller encoding).
- `mem_addr`, out, CPUAWIDTH: byte address to the controller.
- `mem_data`, inout, DWIDTH: shared data bus; driven only during a write grant, high-Z otherwise.
- `init_busy`, out, 1: high during the post-reset hold-off.

## Operation
- FSM states are INIT, IDLE, ACCESS and ACK.
- **INIT**
  - Entered on reset. The init counter runs `MEMDEPTH`+2 cycles after reset deasserts, then the FSM goes to IDLE.
  - `init_busy`=1. Requests are ignored and stay pending.
- **IDLE**: on any pending request, arbitrate, latch the granted port's address, rw and wdata, then go to ACCESS.
- **Arbitration**
  - Only one port pending: that port wins.
  - Both ports pending: round-robin on a `last_grant` bit. The port not served last wins.
  - `last_grant` resets to fetch, so data wins the first tie.
- **Misaligned request** (`addr[1:0]`≠0)
  - No memory access takes place.
  - The FSM goes straight to ACK with the port's err flag set and rdata = 0.
- **ACCESS**
  - `mem_valid`=1 and `mem_addr`/`mem_rw` are held stable for exactly `MEM_LAT` cycles.
  - Writes: `mem_data` is driven with the latched wdata for the whole window.
  - Reads: `mem_data` is sampled on the last ACCESS cycle.
  - The FSM then goes to ACK.
- **ACK**
  - The granted port's ack pulses for 1 cycle, with rdata valid for loads and fetches; store rdata = 0.
  - `mem_valid`=0 and `mem_data` is released.
  - The FSM returns to IDLE.
- Request inputs changing mid-access are ignored, because all request fields are latched at grant.

## Timing
- Reset values:
  - Every output = 0 (`if_ack`, `dm_ack`, the err flags, both rdata outputs, `mem_valid`, `mem_rw`, `mem_addr`).
  - `init_busy`=1.
  - `mem_data` = high-Z.
- Aligned request seen in IDLE at edge N:
  - `mem_valid` is high for cycles N+1 … N+`MEM_LAT`.
  - ack is high in cycle N+`MEM_LAT`+1.
  - A new grant is possible at N+`MEM_LAT`+2.
- Misaligned request at edge N: ack with err in cycle N+1.
- There is at least one idle cycle (`mem_valid`=0) between back-to-back accesses. The controller relies on this to see a fresh strobe.
- A requester must drop or change its request the cycle after ack. A request still held is treated as a new request.
- Reset asserted mid-ACCESS:
  - The access aborts immediately (asynchronously), with `mem_valid`=0 and `mem_data` high-Z.
  - No ack is issued, and INIT restarts.
- Counters are sized `$clog2(MEM_LAT+1)` and `$clog2(MEMDEPTH+3)` bits and saturate; they never wrap.

## Structure
- The FSM state enum, `MEM_RD`=1 / `MEM_WR`=0 constants, and the port-id enum (`PORT_IF`, `PORT_DM`) go in the shared package alongside params.svh values.
- One sub-module, `rr_arb2`: a two-requester round-robin picker holding `last_grant`.
- The tristate driver for `mem_data` stays inline.

## Test plan
- **Init hold-off**: reset pulse, then `if_req`=1 immediately → `init_busy` high for `MEMDEPTH`+2 cycles, then `mem_valid` rises on the first cycle after, and `if_ack` arrives `MEM_LAT`+1 cycles later.
- **Load**: with the controller model holding 0xDEADBEEF at 0x40, `dm_req`=1, `dm_we`=0, `dm_addr`=0x40 → `mem_rw`=1 for 4 cycles, and `dm_rdata`=0xDEADBEEF with `dm_ack`.
- **Store then load**:
  - Store 0x12345678 at 0x80 → `mem_data` driven for 4 cycles with `mem_rw`=0.
  - The following load of 0x80 returns 0x12345678.
- **Contention**: `if_req` and `dm_req` held high continuously → grants alternate DM, IF, DM, IF, each separated by an idle cycle.
- **Misaligned**: `dm_addr`=0x42 → `dm_ack` and `dm_err` in the next cycle, with no `mem_valid` pulse.
- **Reset mid-access**: assert `reset` on the 2nd ACCESS cycle → `mem_valid`=0 and `mem_data`=Z in the same cycle, no ack is issued, and `init_busy`=1.
